demux_stream_n: RTL and testbench
=================================

Name: demux_stream_n

Overview:
- Parametrised, registered 1-to-CHANNELS demultiplexer for a WIDTH-bit data stream.
- Uses valid/ready handshakes on the input and on every output channel.
- Destination comes from a select input (addressed mode) or from an internal round-robin pointer (sequence mode).
- It is the streaming successor to the team's fixed 1x8 combinational demux. It is used wherever one producer feeds several consumers that can stall independently.

Parameters:
- WIDTH, 8, data bits per transfer.
- CHANNELS, 8, number of output channels (2..2**SEL_W).
- SEL_W, 3, select/pointer width; CHANNELS <= 2**SEL_W is required.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  when 0, no new transfer is accepted; a held transfer still drains.
- mode  input  1  0 = addressed (select), 1 = sequence (round-robin pointer).
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept this cycle.
- in_data  input  WIDTH  upstream data.
- select  input  SEL_W  destination channel in mode 0; sampled with the transfer.
- out_valid  output  CHANNELS  per-channel valid; at most one bit set.
- out_ready  input  CHANNELS  per-channel downstream ready.
- out_data  output  CHANNELS*WIDTH  flattened; slice i = bits [i*WIDTH +: WIDTH].
- rr_ptr  output  SEL_W  current round-robin pointer.

Behaviour:
- State
  - One holding stage: data_q (WIDTH), chan_q (SEL_W), full_q (1).
  - Round-robin counter rr_q (SEL_W).
- Reset (async, rst_n=0)
  - full_q=0, data_q=0, chan_q=0, rr_q=0.
  - Hence out_valid=0, out_data=0, rr_ptr=0.
  - in_ready=0 while rst_n=0.
  - Reset mid-transfer discards the held word; no out_valid after release until a new accept.
- Handshake rules
  - drain = full_q && out_ready[chan_q].
  - in_ready = enable && (!full_q || drain). Combinational from out_ready; no combinational path from in_valid.
  - accept = in_valid && in_ready.
- Destination
  - dest = mode ? rr_q : select, evaluated in the accept cycle.
- Accept with dest < CHANNELS
  - Next edge: data_q<=in_data, chan_q<=dest, full_q<=1.
  - Latency: 1 cycle input to out_valid.
  - Throughput: 1 word/cycle while the target is ready.
- Accept with dest >= CHANNELS (only possible with select in mode 0)
  - Word is consumed and dropped.
  - full_q <= 0 if draining, otherwise unchanged (0).
- Drain without accept: full_q<=0.
- Simultaneous drain and accept: the new word replaces the old one in the same edge; no bubble.
- Outputs
  - out_valid[i] = full_q && (chan_q==i).
  - out_data slice chan_q = data_q while full_q; all other slices 0; all slices 0 when empty.
  - Once asserted, out_valid and out_data hold stable until the target's out_ready is sampled high. Stalls on non-target channels have no effect.
- Round-robin
  - rr_q advances only on accept while mode=1.
  - Wraps CHANNELS-1 -> 0 (also for non-power-of-2 CHANNELS).
  - Holds in mode 0.
- Changes to mode, select or enable while full_q=1 do not alter the held transfer.

Optional Feature:
- Macro DEMUX_STREAM_ERR_EN.
- Defined:
  - Adds output err (1): sticky, set on an accept with dest >= CHANNELS.
  - Adds input err_clr (1): synchronous clear; a set in the same cycle wins.
  - Adds output drop_cnt (8): saturating count of dropped words.
  - All cleared by rst_n.
- Undefined: ports and logic absent; out-of-range words are silently dropped as above.

Test Plan:
- Reset: rst_n=0 mid-transfer with full_q=1 -> out_valid=0, in_ready=0, rr_ptr=0; after release, no spurious out_valid.
- Addressed streaming: mode=0, select=5, data 0xA1,0xA2,0xA3 back-to-back, out_ready=all-1 -> out_valid[5] for 3 consecutive cycles starting 1 cycle after the first accept, data in order.
- Backpressure: target ch2 with out_ready[2]=0 for 4 cycles -> in_ready=0, out_data slice 2 held at 0x3C; out_ready[7] toggling has no effect; ch2 ready -> drain and next accept in the same cycle.
- Round-robin: CHANNELS=6, mode=1, 8 words 0x10..0x17 -> channels 0,1,2,3,4,5,0,1; rr_ptr=2 at end; select ignored.
- Out-of-range: CHANNELS=6, mode=0, select=7, word 0xEE -> accepted, no out_valid. With DEMUX_STREAM_ERR_EN: err=1, drop_cnt=1; err_clr -> err=0.
- Enable: enable=0 with full_q=1 and in_valid=1 -> held word drains, in_ready stays 0, rr_ptr unchanged.

Source files
------------

// File: rtl/demux_stream_n.sv
// Registered 1-to-CHANNELS stream demultiplexer with valid/ready on input and every output.
// Optional macro DEMUX_STREAM_ERR_EN adds err / err_clr / drop_cnt for out-of-range selects.
module demux_stream_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          select,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]          rr_ptr
`ifdef DEMUX_STREAM_ERR_EN
    ,
    output logic                      err,
    input  logic                      err_clr,
    output logic [7:0]                drop_cnt
`endif
);

    localparam logic [SEL_W:0]   CHAN_LIM = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] RR_LAST  = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] chan_q;
    logic [SEL_W-1:0] rr_q;
    logic             full_q;

    logic [SEL_W-1:0] dest;
    logic             drain;
    logic             accept;
    logic             in_range;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        drain = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan_q == SEL_W'(i)) drain = full_q & out_ready[i];
        end
    end

    // Gated by rst_n so nothing is taken while the block is held in reset.
    assign in_ready = rst_n && enable && (!full_q || drain);
    assign accept   = in_valid && in_ready;
    assign dest     = mode ? rr_q : select;
    assign in_range = {1'b0, dest} < CHAN_LIM;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            chan_q <= '0;
            full_q <= 1'b0;
            rr_q   <= '0;
        end else begin
            if (accept && in_range) begin
                data_q <= in_data;
                chan_q <= dest;
                full_q <= 1'b1;
            end else if (drain) begin
                full_q <= 1'b0;
            end
            if (accept && mode) begin
                rr_q <= (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (full_q && (chan_q == SEL_W'(i))) begin
                out_valid[i]               = 1'b1;
                out_data[i*WIDTH +: WIDTH] = data_q;
            end
        end
    end

    assign rr_ptr = rr_q;

`ifdef DEMUX_STREAM_ERR_EN
    logic       drop;
    logic       err_q;
    logic [7:0] drop_q;

    assign drop = accept && !in_range;

    // A drop in the same cycle as err_clr keeps err set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            if (drop)         err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
            if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
        end
    end

    assign err      = err_q;
    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_demux_stream_n.sv
// Self-checking bench for demux_stream_n (CHANNELS=6): vector table, corner-case sequences,
// and randomized traffic against a transfer-level reference model.
module tb_demux_stream_n;

    localparam int W  = 8;
    localparam int CH = 6;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic            mode;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic [SW-1:0]   select;
    logic [CH-1:0]   out_valid;
    logic [CH-1:0]   out_ready;
    logic [CH*W-1:0] out_data;
    logic [SW-1:0]   rr_ptr;
`ifdef DEMUX_STREAM_ERR_EN
    logic            err;
    logic            err_clr;
    logic [7:0]      drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux_stream_n #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .select    (select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr)
`ifdef DEMUX_STREAM_ERR_EN
        ,
        .err       (err),
        .err_clr   (err_clr),
        .drop_cnt  (drop_cnt)
`endif
    );

    typedef struct packed {
        logic          en;
        logic          md;
        logic          iv;
        logic [W-1:0]  din;
        logic [SW-1:0] sel;
        logic [CH-1:0] ordy;
        logic          exp_ir;
        logic [CH-1:0] exp_ov;
        logic [W-1:0]  exp_d;
        logic [SW-1:0] exp_rr;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CH*W-1:0] pack_data(input logic [CH-1:0] ov, input logic [W-1:0] d);
        logic [CH*W-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) if (ov[i]) r[i*W +: W] = d;
        return r;
    endfunction

    task automatic drive(input logic en, input logic md, input logic iv, input logic [W-1:0] din,
                         input logic [SW-1:0] sel, input logic [CH-1:0] ordy);
        enable    = en;
        mode      = md;
        in_valid  = iv;
        in_data   = din;
        select    = sel;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ir, input logic [CH-1:0] ov,
                              input logic [W-1:0] d, input logic [SW-1:0] rr);
        check({tag, ".in_ready"},  64'(in_ready),  64'(ir));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        check({tag, ".out_data"},  64'(out_data),  64'(pack_data(ov, d)));
        check({tag, ".rr_ptr"},    64'(rr_ptr),    64'(rr));
    endtask

    // Reference model: one held transfer plus a modulo-CH round-robin index.
    logic       m_full;
    int         m_chan;
    logic [W-1:0] m_data;
    int         m_rr;
    logic       m_err;
    int         m_drop;

    task automatic model_reset();
        m_full = 1'b0; m_chan = 0; m_data = '0; m_rr = 0; m_err = 1'b0; m_drop = 0;
    endtask

    function automatic logic model_ready();
        return enable && (!m_full || out_ready[m_chan]);
    endfunction

    task automatic model_step(input logic clr);
        logic taken, drained;
        int   d;
        drained = m_full && out_ready[m_chan];
        taken   = in_valid && model_ready();
        if (taken) begin
            d = mode ? m_rr : int'(select);
            if (mode) m_rr = (m_rr + 1) % CH;
            if (d < CH) begin
                m_full = 1'b1; m_chan = d; m_data = in_data;
            end else begin
                if (drained) m_full = 1'b0;
                m_err = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end else begin
            if (drained) m_full = 1'b0;
            if (clr) m_err = 1'b0;
        end
    endtask

    initial begin
        logic [CH-1:0] e_ov;
        logic          clr;

        // en md iv din sel ordy | in_ready out_valid data rr
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'hA1, 3'd5, 6'h3F, 1'b1, 6'h00, 8'h00, 3'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'hA2, 3'd5, 6'h3F, 1'b1, 6'h20, 8'hA1, 3'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'hA3, 3'd5, 6'h3F, 1'b1, 6'h20, 8'hA2, 3'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd5, 6'h3F, 1'b1, 6'h20, 8'hA3, 3'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd5, 6'h3F, 1'b1, 6'h00, 8'h00, 3'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h10, 3'd3, 6'h3F, 1'b1, 6'h00, 8'h00, 3'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h11, 3'd3, 6'h3F, 1'b1, 6'h01, 8'h10, 3'd1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h12, 3'd3, 6'h3F, 1'b1, 6'h02, 8'h11, 3'd2};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h13, 3'd3, 6'h3F, 1'b1, 6'h04, 8'h12, 3'd3};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h14, 3'd3, 6'h3F, 1'b1, 6'h08, 8'h13, 3'd4};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h15, 3'd3, 6'h3F, 1'b1, 6'h10, 8'h14, 3'd5};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h16, 3'd3, 6'h3F, 1'b1, 6'h20, 8'h15, 3'd0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h17, 3'd3, 6'h3F, 1'b1, 6'h01, 8'h16, 3'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 3'd3, 6'h3F, 1'b1, 6'h02, 8'h17, 3'd2};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 6'h3F, 1'b1, 6'h00, 8'h00, 3'd2};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 8'hEE, 3'd7, 6'h3F, 1'b1, 6'h00, 8'h00, 3'd2};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd7, 6'h3F, 1'b1, 6'h00, 8'h00, 3'd2};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 8'h55, 3'd6, 6'h3F, 1'b1, 6'h00, 8'h00, 3'd2};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd6, 6'h3F, 1'b1, 6'h00, 8'h00, 3'd2};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 8'h77, 3'd1, 6'h3F, 1'b1, 6'h00, 8'h00, 3'd2};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 8'h88, 3'd7, 6'h3F, 1'b1, 6'h02, 8'h77, 3'd2};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd7, 6'h3F, 1'b1, 6'h00, 8'h00, 3'd2};

        rst_n = 1'b0;
`ifdef DEMUX_STREAM_ERR_EN
        err_clr = 1'b0;
`endif
        drive(1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 6'h3F);
        repeat (3) tick();
        check_outs("reset", 1'b0, 6'h00, 8'h00, 3'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].en, vecs[i].md, vecs[i].iv, vecs[i].din, vecs[i].sel, vecs[i].ordy);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_d, vecs[i].exp_rr);
            tick();
        end

        // Backpressure on ch2; ch5 ready toggles, mode/select wiggle, held word must not move.
        drive(1'b1, 1'b0, 1'b1, 8'h3C, 3'd2, 6'h3B);
        #1 check_outs("bp.accept", 1'b1, 6'h00, 8'h00, 3'd2);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k[0], 1'b1, 8'h3D, (k == 1) ? 3'd4 : 3'd2, k[0] ? 6'h1B : 6'h3B);
            #1 check_outs($sformatf("bp.stall%0d", k), 1'b0, 6'h04, 8'h3C, 3'd2);
            tick();
        end
        drive(1'b1, 1'b0, 1'b1, 8'h3D, 3'd2, 6'h3F);
        #1 check_outs("bp.release", 1'b1, 6'h04, 8'h3C, 3'd2);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 6'h3F);
        #1 check_outs("bp.nobubble", 1'b1, 6'h04, 8'h3D, 3'd2);
        tick();
        #1 check_outs("bp.empty", 1'b1, 6'h00, 8'h00, 3'd2);

        // enable=0: held word drains, nothing new accepted, pointer frozen.
        drive(1'b1, 1'b0, 1'b1, 8'h99, 3'd3, 6'h37);
        #1 check_outs("en.load", 1'b1, 6'h00, 8'h00, 3'd2);
        tick();
        drive(1'b0, 1'b1, 1'b1, 8'hAA, 3'd3, 6'h37);
        #1 check_outs("en.hold", 1'b0, 6'h08, 8'h99, 3'd2);
        tick();
        drive(1'b0, 1'b1, 1'b1, 8'hAA, 3'd3, 6'h3F);
        #1 check_outs("en.drain", 1'b0, 6'h08, 8'h99, 3'd2);
        tick();
        #1 check_outs("en.empty0", 1'b0, 6'h00, 8'h00, 3'd2);
        tick();
        #1 check_outs("en.empty1", 1'b0, 6'h00, 8'h00, 3'd2);

        // Reset while a word is held on ch2 and rr has advanced.
        drive(1'b1, 1'b1, 1'b1, 8'h42, 3'd0, 6'h3B);
        #1 check_outs("rst.load", 1'b1, 6'h00, 8'h00, 3'd2);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 6'h3B);
        #1 check_outs("rst.held", 1'b0, 6'h04, 8'h42, 3'd3);
        rst_n = 1'b0;
        #1 check_outs("rst.async", 1'b0, 6'h00, 8'h00, 3'd0);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 6'h3F);
        #1 check_outs("rst.after0", 1'b1, 6'h00, 8'h00, 3'd0);
        tick();
        #1 check_outs("rst.after1", 1'b1, 6'h00, 8'h00, 3'd0);

`ifdef DEMUX_STREAM_ERR_EN
        drive(1'b1, 1'b0, 1'b1, 8'hEE, 3'd7, 6'h3F);
        #1 check("err.init", 64'({err, drop_cnt}), 64'({1'b0, 8'd0}));
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 3'd7, 6'h3F);
        #1 check("err.set", 64'({err, drop_cnt, out_valid}), 64'({1'b1, 8'd1, 6'h00}));
        err_clr = 1'b1;
        tick();
        #1 check("err.clr", 64'({err, drop_cnt}), 64'({1'b0, 8'd1}));
        drive(1'b1, 1'b0, 1'b1, 8'h66, 3'd6, 6'h3F);
        tick();
        #1 check("err.setwins", 64'({err, drop_cnt}), 64'({1'b1, 8'd2}));
        err_clr = 1'b0;
`endif

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 6'h00);
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 500; c++) begin
            drive($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), 6'($urandom) | 6'($urandom));
            clr = 1'($urandom_range(0, 3) == 0);
`ifdef DEMUX_STREAM_ERR_EN
            err_clr = clr;
`endif
            #1;
            e_ov = m_full ? (CH'(1) << m_chan) : '0;
            check_outs($sformatf("rand%0d", c), model_ready(), e_ov, m_data, SW'(m_rr));
`ifdef DEMUX_STREAM_ERR_EN
            check($sformatf("rand%0d.err", c), 64'({err, drop_cnt}), 64'({m_err, 8'(m_drop)}));
`endif
            model_step(clr);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
